mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port unified memory: instruction fetch (read-only) and data port (load/store).
- Each cycle it picks at most one requester and drives the memory's mode/address/data-in with a same-cycle Mealy command.
- It returns read data one cycle later with a valid strobe.
- Fixed priority to the data port, with a starvation counter that forces a fetch grant after MAX_WAIT consecutive losses.

Parameters:
- MAX_WAIT, 4: consecutive denied fetch cycles before fetch wins priority. Legal range 1..15.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- if_req  input  1  fetch read request; held with if_addr until if_gnt.
- if_addr  input  `WORD  fetch address.
- if_gnt  output  1  fetch accepted this cycle (combinational).
- if_rvalid  output  1  fetch read data valid (registered).
- if_rdata  output  `WORD  fetch read data.
- dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata until dm_gnt.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  `WORD  data address.
- dm_wdata  input  `WORD  store data.
- dm_gnt  output  1  data request accepted this cycle (combinational).
- dm_rvalid  output  1  load data valid (registered).
- dm_rdata  output  `WORD  load data.
- mem_mode  output  [1:0]  memory mode: `memModeIn write, `memModeOut read, `memModeIdle none.
- mem_addr  output  `WORD  memory address.
- mem_wdata  output  `WORD  memory write data.
- mem_rdata  input  `WORD  memory read data. Registered inside the memory; valid the cycle after a `memModeOut edge.

Behaviour:
- Clock port is clk; reset port is reset. Reset is synchronous and active-high. One clock domain.
- While reset is high, outputs are forced combinationally:
  - mem_mode=`memModeIdle, mem_addr=0, mem_wdata=0.
  - if_gnt=0, dm_gnt=0.
- At the first posedge with reset high:
  - if_rvalid=0, dm_rvalid=0.
  - starve_cnt=0.
  - A pending rvalid from a read granted the previous cycle is dropped and never delivered.
- Arbitration (combinational, each cycle, reset low):
  - fetch_pri = (starve_cnt >= MAX_WAIT).
  - Both requesting: dm wins unless fetch_pri, in which case fetch wins.
  - Only one requesting: it wins.
  - Neither requesting: mem_mode=`memModeIdle, mem_addr/mem_wdata hold 0.
- Granted fetch: mem_mode=`memModeOut, mem_addr=if_addr, if_gnt=1.
- Granted data:
  - mem_addr=dm_addr, dm_gnt=1.
  - mem_mode=`memModeIn if dm_we, else `memModeOut.
  - mem_wdata=dm_wdata on stores, 0 otherwise.
- Store: completes at the grant edge. No rvalid is produced. A read of the same address in the next cycle returns the new value.
- Read latency: a read granted in cycle N gives rvalid=1 in cycle N+1 for exactly one cycle.
  - Data is taken from mem_rdata during that cycle.
  - if_rdata and dm_rdata are both wired to mem_rdata; only the rvalid strobes distinguish them.
- Throughput: a new grant may issue in the same cycle an rvalid is returned. Back-to-back reads give one word per cycle.
- Registered state:
  - rd_owner: 2 bits, {none, if, dm}; rvalids decode from it.
  - starve_cnt.
- Starvation counter:
  - if_req && !if_gnt: increment, saturating at MAX_WAIT.
  - if_gnt: clear to 0.
  - !if_req: clear to 0.
- Requester contract: changing a request before its grant is undefined. Arbiter outputs are valid only for the cycle's sampled inputs.
- No combinational path from mem_rdata to any grant.

Decomposition:
- signals.v gains:
  - `memModeIdle, distinct from `memModeIn/`memModeOut.
  - `OWN_NONE / `OWN_IF / `OWN_DM owner codes.
  - `WORD is reused.
- One natural sub-module: mem_arb_starve, the saturating counter and fetch_pri compare, parameterised by MAX_WAIT/CNT_W.
- Priority mux and owner register live in mem_arbiter.

Test Plan:
- Reset 2 cycles with if_req=1 and dm_req=1 held → gnts=0, mem_mode=`memModeIdle, rvalids=0, starve_cnt=0 after reset.
- Lone fetch if_addr=16'h0010, memory preloaded mem[0x10]=16'hBEEF → if_gnt same cycle, mem_mode=`memModeOut; next cycle if_rvalid=1, if_rdata=16'hBEEF, dm_rvalid=0.
- Store dm_we=1, dm_addr=16'h0100, dm_wdata=16'h1234; then load 16'h0100 the following cycle → dm_gnt both cycles, no rvalid after the store, dm_rvalid with 16'h1234 after the load.
- Both requesting every cycle, dm loads 16'h0200+i, MAX_WAIT=4 → dm granted cycles 0–3, fetch granted cycle 4, starve_cnt back to 0, dm granted cycle 5.
- Fetch reads 0x10,0x11,0x12 back-to-back → three consecutive grants, if_rvalid high three consecutive cycles with matching data.
- Read granted cycle N, reset asserted cycle N+1 → rvalid=0 after the reset edge, no stale data delivered, mem_mode=`memModeIdle during reset.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the unified-memory arbiter.
// Word width, memory mode codes and read-owner codes.
package mem_arbiter_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [1:0] MEM_MODE_IDLE = 2'b00;
    localparam logic [1:0] MEM_MODE_IN   = 2'b01;
    localparam logic [1:0] MEM_MODE_OUT  = 2'b10;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DM   = 2'b10
    } owner_e;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating fetch-starvation counter.
// Raises fetch_pri once fetch has lost MAX_WAIT cycles in a row.
module mem_arb_starve #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic fetch_pri
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!if_req || if_gnt) begin
            cnt_d = '0;
        end else if (cnt_q < MAX_CNT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_pri = (cnt_q >= MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the single-port unified memory.
// Data port has priority unless fetch has starved; reads return one cycle later.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [WORD_W-1:0] dm_addr,
    input  logic [WORD_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [WORD_W-1:0] dm_rdata,
    output logic [1:0]        mem_mode,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    logic   fetch_pri;
    owner_e rd_owner_q;
    owner_e rd_owner_d;

    mem_arb_starve #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_gnt    (if_gnt),
        .fetch_pri (fetch_pri)
    );

    always_comb begin
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        mem_mode  = MEM_MODE_IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (dm_req && !(if_req && fetch_pri)) begin
                dm_gnt   = 1'b1;
                mem_addr = dm_addr;
                if (dm_we) begin
                    mem_mode  = MEM_MODE_IN;
                    mem_wdata = dm_wdata;
                end else begin
                    mem_mode = MEM_MODE_OUT;
                end
            end else if (if_req) begin
                if_gnt   = 1'b1;
                mem_mode = MEM_MODE_OUT;
                mem_addr = if_addr;
            end
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (if_gnt) begin
            rd_owner_d = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            rd_owner_d = OWN_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Gating with reset drops a read whose return cycle coincides with reset.
    assign if_rvalid = (rd_owner_q == OWN_IF) && !reset;
    assign dm_rvalid = (rd_owner_q == OWN_DM) && !reset;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule
